// File: rtl/bit_reversal_restore_stream.sv
// Streaming inverse of the cascaded bit-reversal network. Two ping-pong frame
// banks are written in forward-permuted order and read back in natural order.
//
// Bank state | meaning
// EMPTY      | free; the writer may start a new frame here
// FILLING    | writer has stored at least one coefficient of the frame
// FULL       | all 256 coefficients stored, reading not yet started
// DRAINING   | reads issued; returns to EMPTY when k=255 is accepted
module bit_reversal_restore_stream #(
    parameter int SIZE  = 256,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       perm_enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_index,
    output logic             out_last,
    output logic             busy
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    logic [7:0]       perm_q [2];
    logic [7:0]       perm_d [2];
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic             obank_q, obank_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]       out_index_q, out_index_d;
    logic             out_last_q, out_last_d;

    logic [WIDTH-1:0] mem [2*SIZE];

    logic             wr_fire;
    logic             rd_fire;
    logic             out_accept;
    logic [7:0]       rd_addr;

    // Reverse bits [d:0] of x, keep bits [7:d+1]. With d=0 this is the
    // identity, so perm bit 0 has no effect, as intended.
    function automatic logic [7:0] rev_low(input logic [7:0] x, input int d);
        logic [7:0] rev;
        logic [7:0] mask;
        for (int j = 0; j < 8; j++) begin
            rev[j] = x[7-j];
        end
        mask = 8'hFF >> (7 - d);
        return ((rev >> (7 - d)) & mask) | (x & ~mask);
    endfunction

    // Input position holding natural coefficient k: r1 first, r7 last.
    function automatic logic [7:0] restore_addr(input logic [7:0] k, input logic [7:0] pe);
        logic [7:0] a;
        a = k;
        for (int d = 0; d < 8; d++) begin
            if (pe[d]) a = rev_low(a, d);
        end
        return a;
    endfunction

    // Handshake qualifiers; in_ready depends on registered bank state only.
    always_comb begin
        in_ready   = (bank_q[wbank_q] == EMPTY) || (bank_q[wbank_q] == FILLING);
        busy       = (bank_q[0] != EMPTY) || (bank_q[1] != EMPTY);
        wr_fire    = in_valid && in_ready;
        out_accept = out_valid_q && out_ready;
        rd_fire    = ((bank_q[rbank_q] == FULL) || (bank_q[rbank_q] == DRAINING)) &&
                     (!out_valid_q || out_ready);
        rd_addr    = restore_addr(rcnt_q, perm_q[rbank_q]);
    end

    // Bank sequencing, write/read pointers and the output register.
    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        perm_d[0]   = perm_q[0];
        perm_d[1]   = perm_q[1];
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        obank_d     = obank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;

        if (wr_fire) begin
            wcnt_d = wcnt_q + 8'd1;
            if (wcnt_q == 8'd0) begin
                bank_d[wbank_q] = FILLING;
                perm_d[wbank_q] = perm_enable;
            end
            if (wcnt_q == 8'd255) begin
                bank_d[wbank_q] = FULL;
                wbank_d         = ~wbank_q;
            end
        end

        // The accepted output's bank differs from any bank being written or
        // newly read, so these updates never collide.
        if (out_accept) begin
            out_valid_d = 1'b0;
            if (out_last_q) bank_d[obank_q] = EMPTY;
        end

        // A read into the output register happens whenever it is free or
        // being emptied this cycle, giving one coefficient per cycle.
        if (rd_fire) begin
            bank_d[rbank_q] = DRAINING;
            out_valid_d     = 1'b1;
            out_data_d      = mem[{rbank_q, rd_addr}];
            out_index_d     = rcnt_q;
            out_last_d      = (rcnt_q == 8'd255);
            obank_d         = rbank_q;
            rcnt_d          = rcnt_q + 8'd1;
            if (rcnt_q == 8'd255) rbank_d = ~rbank_q;
        end
    end

    // State registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= EMPTY;
                perm_q[b] <= '0;
            end
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            obank_q     <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= bank_d[b];
                perm_q[b] <= perm_d[b];
            end
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            obank_q     <= obank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Frame storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wbank_q, wcnt_q}] <= in_data;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule
